adsr_envelope_bank: RTL

- Multi-voice ADSR envelope generator for the synth voice pipelines.
- Time-multiplexed: one shared update datapath services VOICE_COUNT voices sequentially on each envelope tick.
- Produces a 16-bit amplitude level per voice for the downstream amplitude multiplier.
- Successor to the single-envelope constants: generalises channel count, step scaling and level width.

---
 rtl/adsr_envelope_bank_pkg.sv | 27 ++
 rtl/adsr_envelope_bank_step.sv | 103 ++++++++++
 rtl/adsr_envelope_bank.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_bank_pkg.sv
// ---------------------------------------------------------------------------
// adsr_envelope_bank_pkg
//   Shared configuration for the envelope generators: control and level
//   types, the envelope ceiling, the default rate-step scaling and the
//   per-voice envelope state encoding.
//   No ports (package only).
// ---------------------------------------------------------------------------
package adsr_envelope_bank_pkg;

    localparam int ENV_PARAM_WIDTH     = 7;
    localparam int ENV_LEVEL_WIDTH     = 16;
    localparam int ENVELOPE_STEP_SHIFT = 3;

    typedef logic [ENV_PARAM_WIDTH-1:0] percent_t;
    typedef logic [ENV_LEVEL_WIDTH-1:0] level_t;

    localparam level_t ENVELOPE_CEILING = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_envelope_bank_step.sv
// ---------------------------------------------------------------------------
// adsr_voice_step
//   Pure combinational next-state / next-level function for one ADSR voice.
//   The caller resolves gate edges first and presents the resulting state.
//   Ports:
//     state, level         current (edge-resolved) state and raw level
//     attack, decay        rate controls, 0 = fastest
//     sustain              sustain level control
//     release_rate         release rate control
//     next_state, next_level  values to store at the end of the voice slot
// ---------------------------------------------------------------------------
module adsr_voice_step
    import adsr_envelope_bank_pkg::*;
#(
    parameter int LEVEL_WIDTH = ENV_LEVEL_WIDTH,
    parameter int PARAM_WIDTH = ENV_PARAM_WIDTH,
    parameter int STEP_SHIFT  = ENVELOPE_STEP_SHIFT
) (
    input  env_state_t             state,
    input  logic [LEVEL_WIDTH-1:0] level,
    input  logic [PARAM_WIDTH-1:0] attack,
    input  logic [PARAM_WIDTH-1:0] decay,
    input  logic [PARAM_WIDTH-1:0] sustain,
    input  logic [PARAM_WIDTH-1:0] release_rate,
    output env_state_t             next_state,
    output logic [LEVEL_WIDTH-1:0] next_level
);

    // One extra bit of headroom so sums and compares never wrap.
    localparam int EW = LEVEL_WIDTH + 1;

    function automatic logic [EW-1:0] calc_step(input logic [PARAM_WIDTH-1:0] p);
        logic [EW-1:0] full_scale;
        full_scale = EW'(1) << PARAM_WIDTH;
        return (full_scale - EW'(p)) << STEP_SHIFT;
    endfunction

    logic [LEVEL_WIDTH-1:0] sus_level;

    // Sustain level is the control replicated from the MSB down, so full
    // scale maps to all-ones and zero maps to zero.
    for (genvar j = 0; j < LEVEL_WIDTH; j++) begin : g_sus
        assign sus_level[j] = sustain[PARAM_WIDTH-1-((LEVEL_WIDTH-1-j) % PARAM_WIDTH)];
    end

    logic [EW-1:0] lvl_ext;
    logic [EW-1:0] sus_ext;
    logic [EW-1:0] ceil_ext;
    logic [EW-1:0] step_a;
    logic [EW-1:0] step_d;
    logic [EW-1:0] step_r;
    logic [EW-1:0] attack_sum;

    assign lvl_ext    = {1'b0, level};
    assign sus_ext    = {1'b0, sus_level};
    assign ceil_ext   = {1'b0, {LEVEL_WIDTH{1'b1}}};
    assign step_a     = calc_step(attack);
    assign step_d     = calc_step(decay);
    assign step_r     = calc_step(release_rate);
    assign attack_sum = lvl_ext + step_a;

    always_comb begin
        next_state = state;
        next_level = level;
        case (state)
            IDLE: begin
                next_level = '0;
            end
            ATTACK: begin
                if (attack_sum >= ceil_ext) begin
                    next_level = '1;
                    next_state = DECAY;
                end else begin
                    next_level = LEVEL_WIDTH'(attack_sum);
                end
            end
            DECAY: begin
                if (lvl_ext <= sus_ext + step_d) begin
                    next_level = sus_level;
                    next_state = SUSTAIN;
                end else begin
                    next_level = LEVEL_WIDTH'(lvl_ext - step_d);
                end
            end
            SUSTAIN: begin
                next_level = sus_level;
            end
            RELEASE: begin
                if (lvl_ext <= step_r) begin
                    next_level = '0;
                    next_state = IDLE;
                end else begin
                    next_level = LEVEL_WIDTH'(lvl_ext - step_r);
                end
            end
            default: begin
                next_level = '0;
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/adsr_envelope_bank.sv
// ---------------------------------------------------------------------------
// adsr_envelope_bank
//   Time-multiplexed multi-voice ADSR envelope generator. Each tick starts a
//   sweep that updates one voice per cycle through a shared adsr_voice_step.
//   Optional feature macro: ADSR_VELOCITY_EN (per-voice velocity scaling of
//   the output level, one extra cycle of latency on level and sweep_done).
//   Ports:
//     clock, reset   system clock, synchronous active-high reset
//     tick           single-cycle strobe starting a sweep
//     gate           per-voice note-on level
//     velocity       per-voice velocity (only with ADSR_VELOCITY_EN)
//     attack, decay, sustain, release_rate   shared envelope controls
//     level          registered per-voice envelope level
//     active         per-voice state is not IDLE
//     sweep_done     one-cycle pulse after all voices are updated
//     overrun        sticky: a tick arrived during a sweep and was dropped
// ---------------------------------------------------------------------------
module adsr_envelope_bank
    import adsr_envelope_bank_pkg::*;
#(
    parameter int VOICE_COUNT = 4,
    parameter int LEVEL_WIDTH = ENV_LEVEL_WIDTH,
    parameter int PARAM_WIDTH = ENV_PARAM_WIDTH,
    parameter int STEP_SHIFT  = ENVELOPE_STEP_SHIFT
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   tick,
    input  logic [VOICE_COUNT-1:0]                 gate,
`ifdef ADSR_VELOCITY_EN
    input  logic [VOICE_COUNT-1:0][PARAM_WIDTH-1:0] velocity,
`endif
    input  logic [PARAM_WIDTH-1:0]                 attack,
    input  logic [PARAM_WIDTH-1:0]                 decay,
    input  logic [PARAM_WIDTH-1:0]                 sustain,
    input  logic [PARAM_WIDTH-1:0]                 release_rate,
    output logic [VOICE_COUNT-1:0][LEVEL_WIDTH-1:0] level,
    output logic [VOICE_COUNT-1:0]                 active,
    output logic                                   sweep_done,
    output logic                                   overrun
);

    localparam int IDX_W = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(VOICE_COUNT - 1);

    env_state_t             state     [VOICE_COUNT];
    logic [LEVEL_WIDTH-1:0] raw_level [VOICE_COUNT];
    logic [VOICE_COUNT-1:0] prev_gate;
    logic                   busy;
    logic [IDX_W-1:0]       slot;
    logic                   sweep_end;
    logic                   in_progress;

    logic                   cur_gate;
    logic                   rise;
    logic                   fall;
    env_state_t             cur_state;
    env_state_t             eff_state;
    env_state_t             next_state;
    logic [LEVEL_WIDTH-1:0] next_level;

    // Edges override normal progression; a falling gate on an idle voice
    // has nothing to release.
    assign cur_gate  = gate[slot];
    assign rise      = cur_gate & ~prev_gate[slot];
    assign fall      = ~cur_gate & prev_gate[slot];
    assign cur_state = state[slot];

    always_comb begin
        eff_state = cur_state;
        if (rise) begin
            eff_state = ATTACK;
        end else if (fall && (cur_state != IDLE)) begin
            eff_state = RELEASE;
        end
    end

    adsr_voice_step #(
        .LEVEL_WIDTH (LEVEL_WIDTH),
        .PARAM_WIDTH (PARAM_WIDTH),
        .STEP_SHIFT  (STEP_SHIFT)
    ) u_step (
        .state        (eff_state),
        .level        (raw_level[slot]),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .release_rate (release_rate),
        .next_state   (next_state),
        .next_level   (next_level)
    );

    // Sweep sequencing and per-voice state storage. sweep_end marks the
    // cycle after the last voice slot; ticks are refused until it clears.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy      <= 1'b0;
            slot      <= '0;
            sweep_end <= 1'b0;
            overrun   <= 1'b0;
            prev_gate <= '0;
            for (int i = 0; i < VOICE_COUNT; i++) begin
                state[i]     <= IDLE;
                raw_level[i] <= '0;
            end
        end else begin
            sweep_end <= 1'b0;
            if (tick && in_progress) begin
                overrun <= 1'b1;
            end
            if (tick && !in_progress) begin
                busy <= 1'b1;
                slot <= '0;
            end
            if (busy) begin
                state[slot]     <= next_state;
                raw_level[slot] <= next_level;
                prev_gate[slot] <= cur_gate;
                if (slot == LAST_SLOT) begin
                    busy      <= 1'b0;
                    sweep_end <= 1'b1;
                end else begin
                    slot <= slot + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < VOICE_COUNT; i++) begin : g_active
        assign active[i] = (state[i] != IDLE);
    end

`ifdef ADSR_VELOCITY_EN
    logic [PARAM_WIDTH-1:0] vel_latch    [VOICE_COUNT];
    logic [LEVEL_WIDTH-1:0] scaled_level [VOICE_COUNT];
    logic                   upd_valid;
    logic [IDX_W-1:0]       upd_slot;
    logic                   done_q;
    logic [PARAM_WIDTH:0]   vel_factor;
    logic [LEVEL_WIDTH+PARAM_WIDTH:0] product;

    assign vel_factor = {1'b0, vel_latch[upd_slot]} + 1'b1;
    assign product    = {{(PARAM_WIDTH+1){1'b0}}, raw_level[upd_slot]}
                      * {{LEVEL_WIDTH{1'b0}}, vel_factor};

    // Velocity is captured on the note-on edge; scaling runs one cycle
    // behind the raw update so it always sees the freshly stored values.
    always_ff @(posedge clock) begin
        if (reset) begin
            upd_valid <= 1'b0;
            upd_slot  <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < VOICE_COUNT; i++) begin
                vel_latch[i]    <= '0;
                scaled_level[i] <= '0;
            end
        end else begin
            upd_valid <= busy;
            upd_slot  <= slot;
            done_q    <= sweep_end;
            if (busy && rise) begin
                vel_latch[slot] <= velocity[slot];
            end
            if (upd_valid) begin
                scaled_level[upd_slot] <= LEVEL_WIDTH'(product >> PARAM_WIDTH);
            end
        end
    end

    assign sweep_done  = done_q;
    assign in_progress = busy | sweep_end | done_q;

    for (genvar i = 0; i < VOICE_COUNT; i++) begin : g_level
        assign level[i] = scaled_level[i];
    end
`else
    assign sweep_done  = sweep_end;
    assign in_progress = busy | sweep_end;

    for (genvar i = 0; i < VOICE_COUNT; i++) begin : g_level
        assign level[i] = raw_level[i];
    end
`endif

endmodule
